// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing unit for the 16-bit five-stage CPU.
// Drives the PC and the IF/ID, ID/EX and EX/MEM register enables and flushes.
// It handles load-use bubbles, branch/JAL redirects resolved in MEM,
// data-memory wait states and HALT/resume. It also keeps a saturating
// count of stalled (pc_wen=0) cycles.
//
// Ports:
//   clk, rst               clock; asynchronous active-high reset
//   rs_id/rt_id, *_used_id source operands of the ID instruction
//   rf_waddr_idex, rf_wen_idex, mem2reg_idex   destination of the EX instruction
//   branch_taken_exmem, jal_exmem              redirect resolved in MEM
//   halt_id, resume                            HALT entry / exit
//   dmem_busy                                  data memory not ready
//   pc_wen, pc_sel, *_wen, *_flush             pipeline controls (combinational)
//   state                                      RUN=0 LDSTALL=1 MEMWAIT=2 HALT=3
//   stall_count                                saturating stalled-cycle count
// LD_BUBBLES must be in 1..3.
module hazard_ctrl #(
  parameter int LD_BUBBLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       rs_id,
  input  logic [3:0]       rt_id,
  input  logic             rs_used_id,
  input  logic             rt_used_id,
  input  logic [3:0]       rf_waddr_idex,
  input  logic             rf_wen_idex,
  input  logic             mem2reg_idex,
  input  logic             branch_taken_exmem,
  input  logic             jal_exmem,
  input  logic             halt_id,
  input  logic             dmem_busy,
  input  logic             resume,
  output logic             pc_wen,
  output logic             pc_sel,
  output logic             ifid_wen,
  output logic             ifid_flush,
  output logic             idex_wen,
  output logic             idex_flush,
  output logic             exmem_wen,
  output logic             exmem_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MEMWAIT = 2'd2,
    HALT    = 2'd3
  } state_t;

  // Bubbles still owed after the one inserted on hazard detection.
  localparam logic [1:0] BUB_INIT = 2'(LD_BUBBLES - 1);

  state_t     st_q, st_d;
  logic [1:0] bub_q, bub_d;
  logic       load_use, redirect;

  // R0 is hardwired zero, so a load targeting it never creates a hazard.
  assign load_use = mem2reg_idex & rf_wen_idex & (rf_waddr_idex != 4'd0) &
                    ((rs_used_id & (rs_id == rf_waddr_idex)) |
                     (rt_used_id & (rt_id == rf_waddr_idex)));
  assign redirect = branch_taken_exmem | jal_exmem;

  always_comb begin
    pc_wen      = 1'b1;
    pc_sel      = 1'b0;
    ifid_wen    = 1'b1;
    ifid_flush  = 1'b0;
    idex_wen    = 1'b1;
    idex_flush  = 1'b0;
    exmem_wen   = 1'b1;
    exmem_flush = 1'b0;
    st_d        = st_q;
    bub_d       = bub_q;
    if (rst) begin
      // Outputs follow reset combinationally so they change the moment rst rises.
      pc_wen      = 1'b0;
      ifid_wen    = 1'b0;
      idex_wen    = 1'b0;
      exmem_wen   = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      st_d        = RUN;
      bub_d       = 2'd0;
    end else if (dmem_busy) begin
      // Full freeze in every state. RUN parks in MEMWAIT. The other states hold,
      // and the bubble counter holds with them.
      pc_wen    = 1'b0;
      ifid_wen  = 1'b0;
      idex_wen  = 1'b0;
      exmem_wen = 1'b0;
      if (st_q == RUN) st_d = MEMWAIT;
    end else if (redirect) begin
      // Kill the three wrong-path instructions. This also cancels pending bubbles or HALT.
      pc_sel      = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      st_d        = RUN;
      bub_d       = 2'd0;
    end else begin
      unique case (st_q)
        RUN, MEMWAIT: begin
          st_d = RUN;
          if (load_use) begin
            pc_wen     = 1'b0;
            ifid_wen   = 1'b0;
            idex_flush = 1'b1;
            if (LD_BUBBLES > 1) begin
              st_d  = LDSTALL;
              bub_d = BUB_INIT;
            end
          end else if (halt_id) begin
            pc_wen     = 1'b0;
            ifid_wen   = 1'b0;
            idex_flush = 1'b1;
            st_d       = HALT;
          end
        end
        LDSTALL: begin
          pc_wen     = 1'b0;
          ifid_wen   = 1'b0;
          idex_flush = 1'b1;
          bub_d      = bub_q - 2'd1;
          if (bub_q <= 2'd1) st_d = RUN;
        end
        HALT: begin
          if (resume) begin
            // Drop the HALT sitting in IF/ID and let fetch proceed.
            ifid_flush = 1'b1;
            st_d       = RUN;
          end else begin
            // Hold HALT in ID while the older instructions drain.
            pc_wen     = 1'b0;
            ifid_wen   = 1'b0;
            idex_flush = 1'b1;
          end
        end
        default: st_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= RUN;
      bub_q       <= 2'd0;
      stall_count <= '0;
    end else begin
      st_q  <= st_d;
      bub_q <= bub_d;
      if (!pc_wen && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + 1'b1;
    end
  end

  assign state = st_q;

endmodule
